// File: rtl/clock_disp_pkg.sv
// Shared constants and helpers for the alarm-clock display path.
package clock_disp_pkg;

  localparam logic [1:0] POS_HT = 2'd0;
  localparam logic [1:0] POS_HU = 2'd1;
  localparam logic [1:0] POS_MT = 2'd2;
  localparam logic [1:0] POS_MU = 2'd3;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int DEF_REFRESH_DIV = 100000;
  localparam int DEF_BLINK_HALF  = 125;

  // Per-frame copy of the display inputs, frozen for the whole scan.
  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  mask;
    logic        lz;
  } snap_t;

  // Position 0 is the leftmost digit, held in the top nibble.
  function automatic logic [3:0] pick_digit(input logic [15:0] d, input logic [1:0] pos);
    logic [3:0] r;
    case (pos)
      POS_HT:  r = d[15:12];
      POS_HU:  r = d[11:8];
      POS_MT:  r = d[7:4];
      default: r = d[3:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-N counter advancing on step; tc flags the step that wraps it.
module tick_gen #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic tc
);

  logic [W-1:0] cnt;

  assign tc = step && (cnt == W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (step) cnt <= tc ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with per-digit blink,
// hours-tens leading-zero blanking and invalid-BCD blanking.
module seg_scan_ctrl
  import clock_disp_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int BLINK_HALF  = DEF_BLINK_HALF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blink_mask,
  input  logic        blank_lz,
  output logic [1:0]  en,
  output logic [3:0]  digit,
  output logic        blank,
  output logic        frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(BLINK_HALF + 1);

  logic       tick, wrap, blink_tc;
  logic       blink_phase;
  snap_t      snap, src;
  logic       src_phase;
  logic [1:0] nxt_pos;
  logic [3:0] nxt_digit;
  logic       nxt_blank;

  tick_gen #(.N(REFRESH_DIV), .W(CW)) u_prescale (
    .clk  (clk),
    .rst  (rst),
    .step (1'b1),
    .tc   (tick)
  );

  assign wrap = tick && (en == POS_MU);

  // Counts frame starts; its terminal count flips the blink phase.
  tick_gen #(.N(BLINK_HALF), .W(FW)) u_blink (
    .clk  (clk),
    .rst  (rst),
    .step (wrap),
    .tc   (blink_tc)
  );

  // On a wrap, position 0 already uses the freshly sampled inputs and phase.
  always_comb begin
    nxt_pos   = en + 2'd1;
    src       = wrap ? snap_t'{digits: digits_in, mask: blink_mask, lz: blank_lz} : snap;
    src_phase = blink_phase ^ blink_tc;
    nxt_digit = pick_digit(src.digits, nxt_pos);
    nxt_blank = (src_phase & src.mask[nxt_pos])
              | ((nxt_pos == POS_HT) & src.lz & (nxt_digit == 4'd0))
              | (nxt_digit > BCD_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en          <= POS_HT;
      digit       <= 4'd0;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      snap        <= '0;
      blink_phase <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (wrap) begin
        snap        <= src;
        blink_phase <= src_phase;
      end
      if (tick) begin
        en    <= nxt_pos;
        digit <= nxt_digit;
        blank <= nxt_blank;
      end
    end
  end

endmodule
